// File: rtl/ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl
//
// Sequences single load/store requests into a synchronous-read block RAM.
// One transaction is outstanding at a time. Stores issue one RAM write and
// produce no response. Loads wait out the RAM read latency, capture the data
// and hold it on the response port until it is consumed.
//
// Optional feature (compile-time macro RAM_CLEAR_ON_RESET_EN):
//   When defined, reset enters a CLEAR state that writes zero to every RAM
//   address (0 .. 2**ADDR_W-1, one write per cycle) before going to IDLE.
//   When undefined, reset enters IDLE directly.
//
// Parameters:
//   ADDR_W      RAM address width (depth = 2**ADDR_W)
//   DATA_W      RAM data width
//   RD_LATENCY  cycles from the RAM sampling edge to ram_dout valid (1 or 2)
//
// Ports:
//   clk, reset            single rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake; req_we=1 store, 0 load
//   req_addr, req_wdata   request address and store data
//   rsp_valid/rsp_ready   load-data handshake, rsp_rdata is the load data
//   ram_en, ram_we        registered RAM enable / write enable
//   ram_addr, ram_din     registered RAM address / write data
//   ram_dout              RAM read data
//   busy                  controller is not in IDLE
// ---------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
`ifdef RAM_CLEAR_ON_RESET_EN
    , S_CLEAR
`endif
  } state_e;

`ifdef RAM_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = S_CLEAR;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  // The WAIT state counts down from RD_LATENCY-1; RD_LATENCY is 1 or 2.
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  state_e              state_q, state_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                accept;

`ifdef RAM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_last;

  // The write to the top address is on the RAM pins; its sampling edge ends
  // the clear sweep.
  assign clr_last = ram_en_q && (ram_addr_q == '1);
`endif

  assign accept = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      // ram_we_q still holds the request type during ISSUE.
      S_ISSUE: state_d = ram_we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (lat_cnt_q == 2'd0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
`ifdef RAM_CLEAR_ON_RESET_EN
      S_CLEAR: if (clr_last) state_d = S_IDLE;
`endif
      default: state_d = RESET_STATE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    if (state_q == S_IDLE) begin
      req_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next values (RAM pins, response, counters)
  // -------------------------------------------------------------------------
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    lat_cnt_d   = lat_cnt_q;
`ifdef RAM_CLEAR_ON_RESET_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ram_en_d   = 1'b1;
          ram_we_d   = req_we;
          ram_addr_d = req_addr;
          ram_din_d  = req_wdata;
        end
      end
      S_ISSUE: begin
        if (!ram_we_q) lat_cnt_d = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_dout;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
`ifdef RAM_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        if (!clr_last) begin
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_din_d  = '0;
          ram_addr_d = clr_cnt_q;
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      lat_cnt_q   <= 2'd0;
`ifdef RAM_CLEAR_ON_RESET_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      lat_cnt_q   <= lat_cnt_d;
`ifdef RAM_CLEAR_ON_RESET_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ram_access_ctrl. Two instances: dut (RD_LATENCY=1) and d2
// (RD_LATENCY=2), each connected to a behavioural synchronous-read RAM with
// the matching output latency. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;

`ifdef RAM_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance 1: RD_LATENCY = 1 ----------------
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr, ram_din, ram_dout;
  logic       busy;

  logic [3:0] mem [16] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF,
                           4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] rd1_q = 4'h0;
  int en_cnt = 0;
  int we_cnt = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      rd1_q  <= mem[ram_addr];
      en_cnt <= en_cnt + 1;
      if (ram_we) we_cnt <= we_cnt + 1;
    end
  end
  assign ram_dout = rd1_q;

  ram_access_ctrl #(.ADDR_W(4), .DATA_W(4), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  // ---------------- instance 2: RD_LATENCY = 2 ----------------
  logic       l2_req_valid, l2_req_ready, l2_req_we;
  logic [3:0] l2_req_addr, l2_req_wdata;
  logic       l2_rsp_valid, l2_rsp_ready;
  logic [3:0] l2_rsp_rdata;
  logic       l2_ram_en, l2_ram_we;
  logic [3:0] l2_ram_addr, l2_ram_din, l2_ram_dout;
  logic       l2_busy;

  logic [3:0] mem2 [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                            4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
  logic [3:0] rd2_a_q = 4'h0;
  logic [3:0] rd2_b_q = 4'h0;

  always @(posedge clk) begin
    if (l2_ram_en) begin
      if (l2_ram_we) mem2[l2_ram_addr] <= l2_ram_din;
      rd2_a_q <= mem2[l2_ram_addr];
    end
    rd2_b_q <= rd2_a_q;
  end
  assign l2_ram_dout = rd2_b_q;

  ram_access_ctrl #(.ADDR_W(4), .DATA_W(4), .RD_LATENCY(2)) d2 (
    .clk(clk), .reset(reset),
    .req_valid(l2_req_valid), .req_ready(l2_req_ready), .req_we(l2_req_we),
    .req_addr(l2_req_addr), .req_wdata(l2_req_wdata),
    .rsp_valid(l2_rsp_valid), .rsp_ready(l2_rsp_ready), .rsp_rdata(l2_rsp_rdata),
    .ram_en(l2_ram_en), .ram_we(l2_ram_we), .ram_addr(l2_ram_addr),
    .ram_din(l2_ram_din), .ram_dout(l2_ram_dout), .busy(l2_busy)
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (req_ready !== 1'b1) begin
      $display("FAIL %s_ready_timeout: req_ready=%b want 1", tag, req_ready);
      bad++;
    end
    total++;
  endtask

  task automatic do_load(input logic [3:0] a, output logic [3:0] d);
    int n = 0;
    wait_ready("load");
    req_we    = 1'b0;
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      $display("FAIL load_rsp_timeout: rsp_valid=%b want 1", rsp_valid);
      bad++;
    end
    total++;
    d = rsp_rdata;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if (ram_en !== 1'b0) begin $display("FAIL rst_ram_en: got %b want 0", ram_en); bad++; end
    total++;
    if (ram_we !== 1'b0) begin $display("FAIL rst_ram_we: got %b want 0", ram_we); bad++; end
    total++;
    if (ram_addr !== 4'h0) begin $display("FAIL rst_ram_addr: got %h want 0", ram_addr); bad++; end
    total++;
    if (ram_din !== 4'h0) begin $display("FAIL rst_ram_din: got %h want 0", ram_din); bad++; end
    total++;
    if (rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); bad++; end
    total++;
    if (rsp_rdata !== 4'h0) begin $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); bad++; end
    total++;
    if (req_ready !== !CLR) begin $display("FAIL rst_req_ready: got %b want %b", req_ready, !CLR); bad++; end
    total++;
    if (busy !== CLR) begin $display("FAIL rst_busy: got %b want %b", busy, CLR); bad++; end
    total++;
    reset = 1'b0;
`ifndef RAM_CLEAR_ON_RESET_EN
    tick();
    if (req_ready !== 1'b1 || ram_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL idle_after_rst: ready/en/busy=%b%b%b want 100", req_ready, ram_en, busy);
      bad++;
    end
    total++;
`endif
  endtask

`ifdef RAM_CLEAR_ON_RESET_EN
  task automatic test_clear();
    logic [3:0] d;
    logic [3:0] addrs [3] = '{4'h0, 4'h9, 4'hF};
    for (int k = 0; k < 16; k++) begin
      tick();
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_din !== 4'h0 || ram_addr !== 4'(k)) begin
        $display("FAIL clear_write_%0d: en/we/din/addr=%b/%b/%h/%h want 1/1/0/%h",
                 k, ram_en, ram_we, ram_din, ram_addr, 4'(k));
        bad++;
      end
      total++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL clear_flags_%0d: ready/busy=%b%b want 01", k, req_ready, busy);
        bad++;
      end
      total++;
    end
    tick();
    if (ram_en !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL clear_done: en/ready/busy=%b%b%b want 010", ram_en, req_ready, busy);
      bad++;
    end
    total++;
    for (int i = 0; i < 3; i++) begin
      do_load(addrs[i], d);
      if (d !== 4'h0) begin $display("FAIL clear_load_%h: got %h want 0", addrs[i], d); bad++; end
      total++;
    end
  endtask
`endif

  task automatic test_store_load();
    wait_ready("store_load");
    req_we = 1'b1; req_addr = 4'h3; req_wdata = 4'hA; req_valid = 1'b1;
    tick();  // store accepted
    req_valid = 1'b0;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'h3 || ram_din !== 4'hA) begin
      $display("FAIL store_issue: en/we/addr/din=%b/%b/%h/%h want 1/1/3/a", ram_en, ram_we, ram_addr, ram_din);
      bad++;
    end
    total++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL store_busy: ready/busy=%b%b want 01", req_ready, busy);
      bad++;
    end
    total++;
    tick();  // RAM samples the write
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL store_done: en/we/ready=%b%b%b want 001", ram_en, ram_we, req_ready);
      bad++;
    end
    total++;
    if (mem[3] !== 4'hA) begin $display("FAIL store_mem: got %h want a", mem[3]); bad++; end
    total++;
    req_we = 1'b0; req_addr = 4'h3; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();  // load accepted
    req_valid = 1'b0;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'h3 || rsp_valid !== 1'b0) begin
      $display("FAIL load_issue: en/we/addr/rv=%b/%b/%h/%b want 1/0/3/0", ram_en, ram_we, ram_addr, rsp_valid);
      bad++;
    end
    total++;
    tick();
    if (rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
      $display("FAIL load_t1: rv/en=%b%b want 00", rsp_valid, ram_en);
      bad++;
    end
    total++;
    tick();
    if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) begin
      $display("FAIL load_rsp: rv/data=%b/%h want 1/a", rsp_valid, rsp_rdata);
      bad++;
    end
    total++;
    tick();
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 4'hA) begin
      $display("FAIL load_consumed: rv/ready/data=%b/%b/%h want 0/1/a", rsp_valid, req_ready, rsp_rdata);
      bad++;
    end
    total++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    wait_ready("bp");
    req_we = 1'b1; req_addr = 4'h5; req_wdata = 4'h6; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    req_we = 1'b0; req_addr = 4'h5; req_valid = 1'b1; rsp_ready = 1'b0;
    tick();  // load accepted
    // A store is presented while the load is outstanding; it must wait.
    req_we = 1'b1; req_addr = 4'h5; req_wdata = 4'hF; req_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h6 || req_ready !== 1'b0 || ram_en !== 1'b0) begin
        $display("FAIL bp_hold_%0d: rv/data/ready/en=%b/%h/%b/%b want 1/6/0/0",
                 i, rsp_valid, rsp_rdata, req_ready, ram_en);
        bad++;
      end
      total++;
      if (i < 3) tick();
    end
    rsp_ready = 1'b1;
    tick();
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ram_en !== 1'b0) begin
      $display("FAIL bp_release: rv/ready/en=%b%b%b want 010", rsp_valid, req_ready, ram_en);
      bad++;
    end
    total++;
    tick();  // waiting store accepted now
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'h5 || ram_din !== 4'hF) begin
      $display("FAIL bp_pending_store: en/we/addr/din=%b/%b/%h/%h want 1/1/5/f", ram_en, ram_we, ram_addr, ram_din);
      bad++;
    end
    total++;
    tick();
  endtask

  task automatic test_back_to_back();
    int en0 = en_cnt;
    int we0 = we_cnt;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int op = 0; op < 2; op++) begin
        int n = 0;
        req_we    = (op == 0);
        req_addr  = 4'(a);
        req_wdata = 4'(15 - a);
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (req_ready !== 1'b1) begin $display("FAIL b2b_ready_timeout: a=%0d op=%0d", a, op); bad++; end
        total++;
        tick();  // accepted
        if (op == 1) begin
          n = 0;
          while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
          if (rsp_valid !== 1'b1 || rsp_rdata !== 4'(15 - a)) begin
            $display("FAIL b2b_read_%0d: rv/data=%b/%h want 1/%h", a, rsp_valid, rsp_rdata, 4'(15 - a));
            bad++;
          end
          total++;
        end
      end
    end
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    if (en_cnt - en0 !== 32 || we_cnt - we0 !== 16) begin
      $display("FAIL b2b_pulse_count: en=%0d we=%0d want 32 16", en_cnt - en0, we_cnt - we0);
      bad++;
    end
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL b2b_end: rv/ready=%b%b want 01", rsp_valid, req_ready);
      bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    logic [3:0] exp7 = CLR ? 4'h0 : 4'h8;
    // Store aborted before its sampling edge.
    wait_ready("rst_store");
    req_we = 1'b1; req_addr = 4'h9; req_wdata = 4'h3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'h0 || ram_din !== 4'h0 ||
        rsp_rdata !== 4'h0 || req_ready !== !CLR || busy !== CLR) begin
      $display("FAIL rst_async_issue: en/we/addr/din/data/ready/busy=%b/%b/%h/%h/%h/%b/%b",
               ram_en, ram_we, ram_addr, ram_din, rsp_rdata, req_ready, busy);
      bad++;
    end
    total++;
    tick();
    if (mem[9] !== 4'h6) begin $display("FAIL rst_store_dropped: mem9=%h want 6", mem[9]); bad++; end
    total++;
    reset = 1'b0;
    // Load aborted in WAIT.
    wait_ready("rst_load");
    req_we = 1'b0; req_addr = 4'h7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();  // now in WAIT
    reset = 1'b1;
    #1;
    if (rsp_valid !== 1'b0 || ram_en !== 1'b0 || busy !== CLR) begin
      $display("FAIL rst_async_wait: rv/en/busy=%b%b%b want 00%b", rsp_valid, ram_en, busy, CLR);
      bad++;
    end
    total++;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      if (rsp_valid !== 1'b0) begin $display("FAIL rst_no_rsp_%0d: rv=%b want 0", i, rsp_valid); bad++; end
      total++;
    end
    rsp_ready = 1'b0;
    do_load(4'h7, d);
    if (d !== exp7) begin $display("FAIL rst_reload7: got %h want %h", d, exp7); bad++; end
    total++;
  endtask

  task automatic test_latency2();
    int n = 0;
    while (l2_req_ready !== 1'b1 && n < 40) begin tick(); n++; end
    if (l2_req_ready !== 1'b1) begin $display("FAIL l2_ready_timeout: ready=%b", l2_req_ready); bad++; end
    total++;
    l2_req_we = 1'b1; l2_req_addr = 4'hC; l2_req_wdata = 4'h5; l2_req_valid = 1'b1;
    tick();
    l2_req_valid = 1'b0;
    tick();
    l2_req_we = 1'b0; l2_req_valid = 1'b1; l2_rsp_ready = 1'b1;
    tick();  // load accepted at T
    l2_req_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      if (l2_rsp_valid !== 1'b0) begin $display("FAIL l2_early_T%0d: rv=%b want 0", i, l2_rsp_valid); bad++; end
      total++;
    end
    tick();  // T+3
    if (l2_rsp_valid !== 1'b1 || l2_rsp_rdata !== 4'h5) begin
      $display("FAIL l2_rsp: rv/data=%b/%h want 1/5", l2_rsp_valid, l2_rsp_rdata);
      bad++;
    end
    total++;
    tick();
    if (l2_rsp_valid !== 1'b0 || l2_req_ready !== 1'b1) begin
      $display("FAIL l2_consumed: rv/ready=%b%b want 01", l2_rsp_valid, l2_req_ready);
      bad++;
    end
    total++;
    l2_rsp_ready = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0; req_wdata = 4'h0; rsp_ready = 1'b0;
    l2_req_valid = 1'b0; l2_req_we = 1'b0; l2_req_addr = 4'h0; l2_req_wdata = 4'h0;
    l2_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
`ifdef RAM_CLEAR_ON_RESET_EN
    test_clear();
`endif
    test_store_load();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_latency2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
